// File: rtl/msg_decoder_pkg.sv
// ---------------------------------------------------------------------------
// msg_decoder_pkg : shared constants, LFSR tap table and FSM state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package msg_decoder_pkg;

  localparam logic [7:0] SPACE     = 8'h20;
  localparam int         MSG_LEN   = 64;
  localparam logic [3:0] PTRN_NONE = 4'hF;
  localparam int         NUM_PTRN  = 9;

  localparam logic [6:0] LFSR_PTRN [NUM_PTRN] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEARCH    = 3'd2,
    DECODE_RD = 3'd3,
    DECODE_WR = 3'd4,
    PAD       = 3'd5,
    DONE      = 3'd6
  } state_t;

  // Out-of-range indices fall back to entry 0; the FSM never produces them.
  function automatic logic [6:0] ptrn_tap(input logic [3:0] idx);
    logic [6:0] tap;
    tap = LFSR_PTRN[0];
    for (int i = 0; i < NUM_PTRN; i++) begin
      if (idx == 4'(i)) tap = LFSR_PTRN[i];
    end
    return tap;
  endfunction

endpackage

`default_nettype wire

// File: rtl/msg_decoder_if.sv
// ---------------------------------------------------------------------------
// msg_decoder_if : control handshake and single-port data-memory bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface msg_decoder_if;
  logic       Start;
  logic       Ack;
  logic [7:0] MemAddr;
  logic       MemRdEn;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;
  logic [3:0] PtrnNo;
  logic       NoMatch;
  logic       ParityErr;

  modport master (
    input  Start, MemRdData,
    output Ack, MemAddr, MemRdEn, MemWrEn, MemWrData, PtrnNo, NoMatch, ParityErr
  );

  modport slave (
    output Start, MemRdData,
    input  Ack, MemAddr, MemRdEn, MemWrEn, MemWrData, PtrnNo, NoMatch, ParityErr
  );
endinterface

`default_nettype wire

// File: rtl/msg_decoder_lfsr7_step.sv
// ---------------------------------------------------------------------------
// lfsr7_step : one combinational step of the 7-bit Fibonacci LFSR
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr7_step (
  input  logic [6:0] cur,
  input  logic [6:0] tap,
  output logic [6:0] nxt
);
  assign nxt = {cur[5:0], ^(cur & tap)};
endmodule

`default_nettype wire

// File: rtl/msg_decoder.sv
// ---------------------------------------------------------------------------
// msg_decoder : recovers LFSR tap/seed from the space preamble and decrypts
//               the 64-byte ciphertext. Optional macro: PARITY_CHECK_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module msg_decoder
  import msg_decoder_pkg::*;
#(
  parameter int PRE_MIN = 10,
  parameter int CT_BASE = 64,
  parameter int PT_BASE = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  msg_decoder_if.master bus
);

  localparam int         LDW     = $clog2(PRE_MIN + 1);
  localparam logic [7:0] CT_ADDR = 8'(CT_BASE);
  localparam logic [7:0] PT_ADDR = 8'(PT_BASE);

  state_t           state, state_nxt;
  logic [LDW-1:0]   ld_cnt;
  logic [3:0]       ptrn;
  logic [5:0]       idx;
  logic [6:0]       wptr;
  logic             skip;
  logic [6:0]       lfsr;
  logic [6:0]       tap;
  logic [6:0]       pre_buf [PRE_MIN];
  logic [3:0]       ptrn_no;
  logic             no_match;
  logic             parity_err;

  logic [6:0]       seed;
  logic [6:0]       srch_tap;
  logic [PRE_MIN-2:0] hit;
  logic             match;
  logic [6:0]       lfsr_nxt;
  logic [7:0]       plain;
  logic             par_bad;
  logic             write_now;
  logic [7:0]       wr_data;
  logic [6:0]       wptr_after;

  logic [7:0]       mem_addr;
  logic             mem_rd_en;
  logic             mem_wr_en;
  logic [7:0]       mem_wr_data;

  assign seed     = pre_buf[0] ^ SPACE[6:0];
  assign srch_tap = ptrn_tap(ptrn);

  // Preamble byte k must equal the k-th LFSR successor of the seed.
  for (genvar k = 1; k < PRE_MIN; k++) begin : g_chain
    logic [6:0] prev;
    logic [6:0] st;
    if (k == 1) begin : g_first
      assign prev = seed;
    end else begin : g_next
      assign prev = g_chain[k-1].st;
    end
    lfsr7_step u_step (.cur(prev), .tap(srch_tap), .nxt(st));
    assign hit[k-1] = ((pre_buf[k] ^ SPACE[6:0]) == st);
  end

  assign match = &hit;

  lfsr7_step u_dec_step (.cur(lfsr), .tap(tap), .nxt(lfsr_nxt));

  assign plain = {1'b0, bus.MemRdData[6:0] ^ lfsr};

`ifdef PARITY_CHECK_EN
  assign par_bad = (bus.MemRdData[7] != ^bus.MemRdData[6:0]);
`else
  logic unused_rd_msb;
  assign unused_rd_msb = bus.MemRdData[7];
  assign par_bad       = 1'b0;
`endif

  // A parity-failed byte is always emitted so the error stays visible.
  assign write_now  = par_bad || !(skip && (plain == SPACE));
  assign wr_data    = par_bad ? 8'h80 : plain;
  assign wptr_after = write_now ? (wptr + 7'd1) : wptr;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!bus.Start) state_nxt = LOAD;
      LOAD:      if (ld_cnt == LDW'(PRE_MIN)) state_nxt = SEARCH;
      SEARCH: begin
        if (match)                             state_nxt = DECODE_RD;
        else if (ptrn == 4'(NUM_PTRN - 1))     state_nxt = DONE;
      end
      DECODE_RD: state_nxt = DECODE_WR;
      DECODE_WR: begin
        if (idx == 6'(MSG_LEN - 1))
          state_nxt = (wptr_after == 7'(MSG_LEN)) ? DONE : PAD;
        else
          state_nxt = DECODE_RD;
      end
      PAD:       if (wptr == 7'(MSG_LEN - 1)) state_nxt = DONE;
      DONE:      if (bus.Start) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr    = 8'h00;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    case (state)
      LOAD: begin
        if (ld_cnt < LDW'(PRE_MIN)) begin
          mem_rd_en = 1'b1;
          mem_addr  = CT_ADDR + 8'(ld_cnt);
        end
      end
      DECODE_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = CT_ADDR + {2'b00, idx};
      end
      DECODE_WR: begin
        mem_wr_en   = write_now;
        mem_addr    = PT_ADDR + {1'b0, wptr};
        mem_wr_data = wr_data;
      end
      PAD: begin
        mem_wr_en   = 1'b1;
        mem_addr    = PT_ADDR + {1'b0, wptr};
        mem_wr_data = SPACE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ld_cnt     <= '0;
      ptrn       <= 4'd0;
      idx        <= 6'd0;
      wptr       <= 7'd0;
      skip       <= 1'b1;
      lfsr       <= 7'd0;
      tap        <= 7'd0;
      ptrn_no    <= 4'd0;
      no_match   <= 1'b0;
      parity_err <= 1'b0;
      for (int k = 0; k < PRE_MIN; k++) pre_buf[k] <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.Start) begin
            ld_cnt     <= '0;
            ptrn       <= 4'd0;
            idx        <= 6'd0;
            wptr       <= 7'd0;
            skip       <= 1'b1;
            no_match   <= 1'b0;
            parity_err <= 1'b0;
          end
        end
        LOAD: begin
          ld_cnt <= ld_cnt + LDW'(1);
          // Data read in cycle n-1 lands in buffer slot n-1 during cycle n.
          for (int k = 0; k < PRE_MIN; k++) begin
            if (ld_cnt == LDW'(k + 1)) pre_buf[k] <= bus.MemRdData[6:0];
          end
        end
        SEARCH: begin
          if (match) begin
            ptrn_no <= ptrn;
            lfsr    <= seed;
            tap     <= srch_tap;
          end else if (ptrn == 4'(NUM_PTRN - 1)) begin
            ptrn_no  <= PTRN_NONE;
            no_match <= 1'b1;
          end else begin
            ptrn <= ptrn + 4'd1;
          end
        end
        DECODE_WR: begin
          lfsr <= lfsr_nxt;
          idx  <= idx + 6'd1;
          if (write_now) begin
            wptr <= wptr + 7'd1;
            skip <= 1'b0;
          end
          if (par_bad) parity_err <= 1'b1;
        end
        PAD: wptr <= wptr + 7'd1;
        default: ;
      endcase
    end
  end

  assign bus.Ack       = (state == DONE);
  assign bus.MemAddr   = mem_addr;
  assign bus.MemRdEn   = mem_rd_en;
  assign bus.MemWrEn   = mem_wr_en;
  assign bus.MemWrData = mem_wr_data;
  assign bus.PtrnNo    = ptrn_no;
  assign bus.NoMatch   = no_match;
  assign bus.ParityErr = parity_err;

endmodule

`default_nettype wire

// File: tb/tb_msg_decoder.sv
// ---------------------------------------------------------------------------
// tb_msg_decoder : table-driven and directed checks of msg_decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_msg_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msg_decoder_if bus ();

  msg_decoder #(.PRE_MIN(10), .CT_BASE(64), .PT_BASE(0)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  localparam logic [6:0] TAPS [9] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  logic [7:0] mem      [128];
  logic [7:0] init_img [128];
  logic [7:0] pt       [64];
  logic       init_req = 1'b0;
  logic       overlap  = 1'b0;

  int total = 0;
  int bad   = 0;

  // Single-port synchronous memory: read data is valid the cycle after RdEn.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_img[i];
    end else if (bus.MemWrEn) begin
      mem[bus.MemAddr[6:0]] <= bus.MemWrData;
    end
    if (bus.MemRdEn) bus.MemRdData <= mem[bus.MemAddr[6:0]];
    if (bus.MemRdEn && bus.MemWrEn) overlap <= 1'b1;
  end

  typedef struct {
    int         msg_id;
    int         ptrn;
    logic [6:0] seed;
    int         pre;
    bit         corrupt;
    logic [3:0] exp_ptrn;
    bit         exp_nomatch;
    int         exp_lat;
  } vec_t;

  vec_t  vecs [6];
  string msgs [5];

  function automatic logic [6:0] next7(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_pt(input int msg_id, input int pre);
    string m;
    m = msgs[msg_id];
    for (int i = 0; i < 64; i++) begin
      if (i < pre || (i - pre) >= m.len()) pt[i] = 8'h20;
      else                                 pt[i] = m[i - pre];
    end
  endtask

  task automatic build_image(input int p, input logic [6:0] seed, input bit corrupt65, input bit flip80);
    logic [6:0] s;
    logic [6:0] low;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      init_img[i] = 8'hA5;
      low = pt[i][6:0] ^ s;
      init_img[64 + i] = {^low, low};
      s = next7(s, TAPS[p]);
    end
    if (corrupt65) init_img[65] = init_img[65] ^ 8'h40;
    if (flip80)    init_img[80] = init_img[80] ^ 8'h80;
  endtask

  task automatic run_case(input string name, input int p, input logic [6:0] seed,
                          input bit corrupt65, input bit flip80,
                          input logic [3:0] exp_ptrn, input bit exp_nomatch, input int exp_lat);
    int         cyc;
    int         first;
    int         mism;
    bit         exp_par;
    logic [7:0] exp_mem [64];

    build_image(p, seed, corrupt65, flip80);
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req  = 1'b0;
    bus.Start = 1'b0;
    cyc = 0;
    while (cyc < 300 && bus.Ack !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end

`ifdef PARITY_CHECK_EN
    exp_par = flip80;
`else
    exp_par = 1'b0;
`endif
    check({name, " latency"},   32'(cyc),             32'(exp_lat));
    check({name, " PtrnNo"},    32'(bus.PtrnNo),      32'(exp_ptrn));
    check({name, " NoMatch"},   32'(bus.NoMatch),     32'(exp_nomatch));
    check({name, " ParityErr"}, 32'(bus.ParityErr),   32'(exp_par));

    bus.Start = 1'b1;
    @(posedge clk); #1;
    check({name, " ack_drop"}, 32'(bus.Ack), 32'd0);

    first = 64;
    for (int i = 63; i >= 0; i--) if (pt[i] != 8'h20) first = i;
    for (int j = 0; j < 64; j++) begin
      if (exp_nomatch)      exp_mem[j] = 8'hA5;
      else if (first + j < 64) exp_mem[j] = pt[first + j];
      else                  exp_mem[j] = 8'h20;
    end
    if (exp_par && !exp_nomatch && first <= 16) exp_mem[16 - first] = 8'h80;

    mism = 0;
    for (int j = 0; j < 64; j++) if (mem[j] !== exp_mem[j]) mism++;
    check({name, " plaintext_mismatch_bytes"}, 32'(mism), 32'd0);
  endtask

  initial begin
    msgs[0] = "Mr. Watson, come here. I want to see you.";
    msgs[1] = "Hello, world!";
    msgs[2] = "";
    msgs[3] = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    msgs[4] = "x";

    // msg, ptrn, seed, pre, corrupt, exp_ptrn, exp_nomatch, exp_lat (141+p+pre)
    vecs[0] = '{0, 0, 7'h01, 10, 1'b0, 4'd0, 1'b0, 151};
    vecs[1] = '{1, 4, 7'h55, 12, 1'b0, 4'd4, 1'b0, 157};
    vecs[2] = '{2, 8, 7'h7F, 64, 1'b0, 4'd8, 1'b0, 213};
    vecs[3] = '{0, 2, 7'h33, 10, 1'b1, 4'hF, 1'b1, 21};
    vecs[4] = '{3, 7, 7'h0A, 15, 1'b0, 4'd7, 1'b0, 163};
    vecs[5] = '{4, 1, 7'h40, 11, 1'b0, 4'd1, 1'b0, 153};

    bus.Start = 1'b1;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset Ack",       32'(bus.Ack),       32'd0);
    check("reset MemRdEn",   32'(bus.MemRdEn),   32'd0);
    check("reset MemWrEn",   32'(bus.MemWrEn),   32'd0);
    check("reset MemAddr",   32'(bus.MemAddr),   32'd0);
    check("reset MemWrData", 32'(bus.MemWrData), 32'd0);
    check("reset PtrnNo",    32'(bus.PtrnNo),    32'd0);
    check("reset NoMatch",   32'(bus.NoMatch),   32'd0);
    check("reset ParityErr", 32'(bus.ParityErr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      fill_pt(vecs[v].msg_id, vecs[v].pre);
      run_case($sformatf("vec%0d", v), vecs[v].ptrn, vecs[v].seed, vecs[v].corrupt, 1'b0,
               vecs[v].exp_ptrn, vecs[v].exp_nomatch, vecs[v].exp_lat);
    end

    for (int r = 0; r < 50; r++) begin
      int         p;
      int         pre;
      logic [6:0] sd;
      p   = int'($urandom_range(0, 8));
      pre = int'($urandom_range(10, 15));
      sd  = 7'($urandom_range(1, 127));
      for (int i = 0; i < 64; i++) pt[i] = (i < pre) ? 8'h20 : 8'($urandom_range(32, 126));
      pt[pre] = 8'($urandom_range(33, 126));
      run_case($sformatf("rand%0d", r), p, sd, 1'b0, 1'b0, 4'(p), 1'b0, 141 + p + pre);
    end

    // Reset in the middle of DECODE, then a clean rerun of the same message.
    fill_pt(0, 10);
    build_image(5, 7'h19, 1'b0, 1'b0);
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req  = 1'b0;
    bus.Start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
    end
    rst       = 1'b1;
    bus.Start = 1'b1;
    @(posedge clk); #1;
    check("midrst Ack",     32'(bus.Ack),     32'd0);
    check("midrst MemRdEn", 32'(bus.MemRdEn), 32'd0);
    check("midrst MemWrEn", 32'(bus.MemWrEn), 32'd0);
    check("midrst PtrnNo",  32'(bus.PtrnNo),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_case("rerun", 5, 7'h19, 1'b0, 1'b0, 4'd5, 1'b0, 156);

    // Bit 7 of ciphertext byte 80 flipped.
    fill_pt(3, 10);
    run_case("parity", 3, 7'h2B, 1'b0, 1'b1, 4'd3, 1'b0, 154);

    check("rd_wr_overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
